fir_coef_ctrl: RTL and testbench
================================

Name: fir_coef_ctrl

Overview:
Configuration controller for the 8-bit FIR filter. A host writes tap coefficients into a shadow bank through a valid/ready port, then issues a commit. The controller swaps shadow to active on the next sample boundary, flushes the FIR delay line and gates the sample stream, so the filter never runs with a half-updated coefficient set. It sits between the input sample source and the FIR and drives the FIR's coefficient bus.

Parameters:
NTAPS, 4, number of FIR taps / coefficients
CW, 8, coefficient width in bits
AW, 2, coefficient address width (must satisfy 2**AW >= NTAPS)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
wr_valid  in  1  host coefficient write request
wr_ready  out  1  controller can accept a write
wr_addr  in  AW  tap index of the write
wr_data  in  CW  coefficient value
commit  in  1  request to activate the shadow bank (single-cycle pulse)
sample_en  in  1  sample-boundary strobe from the sample source
x_in  in  8  input sample from the source
x_out  out  8  sample to FIR x; forced to 0 during flush
coef  out  NTAPS*CW  active coefficients to FIR, tap k at bits [k*CW +: CW]
fir_clr  out  1  one-cycle FIR delay-line clear
busy  out  1  commit in progress
done  out  1  one-cycle pulse when commit completes
err  out  1  one-cycle pulse on write to out-of-range address

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE.
  - Outputs: wr_ready=0, busy=0, done=0, err=0, fir_clr=0, x_out=0.
  - Active bank = DEFAULT_COEF (every tap 8'h01); shadow bank = all 0.
  - The first cycle after reset release has wr_ready=1.
  - Reset mid-commit aborts it; no done pulse.
- States: IDLE, WAIT_SMP, FLUSH.
- IDLE:
  - wr_ready=1.
  - On a write handshake (wr_valid && wr_ready), shadow[wr_addr] <= wr_data.
  - If wr_addr >= NTAPS, the write is dropped and err pulses in the next cycle.
  - x_out <= x_in (registered, 1-cycle latency).
- commit in IDLE -> WAIT_SMP next cycle; busy=1, wr_ready=0.
  - A write and a commit in the same cycle are both honoured; the written value is part of the committed set.
  - commit outside IDLE is ignored.
- WAIT_SMP:
  - x_out keeps passing x_in.
  - sample_en is sampled starting the cycle after commit. sample_en in the commit cycle itself does not trigger the swap.
  - On sample_en at cycle s: active <= shadow, flush counter <= NTAPS-1, state -> FLUSH. The new coef value is visible at s+1.
- FLUSH:
  - Lasts exactly NTAPS cycles (s+1 .. s+NTAPS).
  - fir_clr=1 in cycle s+1 only.
  - x_out=0 for all NTAPS cycles; x_in is discarded.
  - The counter decrements each cycle; at 0 the state -> IDLE.
- Completion: at s+NTAPS+1, done=1 for one cycle, busy=0, wr_ready=1, x_out passthrough resumes.
- Shadow bank is retained after a commit; it is not cleared. A second commit without writes reloads the same set.
- coef is driven only from active-bank registers, never combinationally from the shadow bank or the write port.
- busy is high from the cycle after commit through the last FLUSH cycle inclusive.

Decomposition:
- Package fir_pkg: NTAPS, CW, AW defaults, DEFAULT_COEF constant, state enum (IDLE, WAIT_SMP, FLUSH) as a typedef, coef_t = logic [CW-1:0].
- One sub-module, fir_coef_bank: shadow and active register arrays, write port, swap strobe, flattened coef output.
- FSM, flush counter and sample gating stay in fir_coef_ctrl.

Test Plan:
1. Reset: hold rst=0 two cycles with random inputs -> coef=32'h01010101, wr_ready=0, busy=0, x_out=0. First cycle after release: wr_ready=1.
2. Write taps 0..3 = 8'h10,20,30,40, commit, sample_en 3 cycles later at cycle s -> coef=32'h40302010 at s+1, fir_clr high only at s+1, x_out=0 for s+1..s+4, done pulse at s+5 with busy=0.
3. Write tap 2=8'h55 in the same cycle as commit -> committed coef byte 2 = 8'h55.
4. sample_en asserted in the commit cycle and not again for 5 cycles -> no swap until the later strobe; x_out passes x_in meanwhile; wr_valid held high is never acknowledged while busy.
5. With AW=3, NTAPS=4: write addr 5 data 8'hFF -> err pulses one cycle, shadow unchanged; a later commit shows no 8'hFF byte in coef.
6. Drop rst to 0 in the second FLUSH cycle -> coef returns to 32'h01010101, no done pulse, state IDLE (wr_ready=1) after release.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR coefficient controller.
package fir_pkg;
  localparam int DEF_NTAPS = 4;
  localparam int DEF_CW    = 8;
  localparam int DEF_AW    = 2;

  typedef logic [DEF_CW-1:0] coef_t;

  localparam coef_t DEFAULT_COEF = 8'h01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SMP = 2'd1,
    FLUSH    = 2'd2
  } state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow/active coefficient registers.
// The shadow bank absorbs host writes; the active bank only changes on swap.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int CW    = DEF_CW,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [CW-1:0]       data,
  input  logic                swap,
  output logic [NTAPS*CW-1:0] coef
);

  logic [CW-1:0] shadow [NTAPS];
  logic [CW-1:0] active [NTAPS];

  // Out-of-range addresses match no tap, so such writes are dropped here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= CW'(DEFAULT_COEF);
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (we && int'(addr) == k)
          shadow[k] <= data;
        if (swap)
          active[k] <= shadow[k];
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_out
    assign coef[k*CW +: CW] = active[k];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: commit FSM, flush counter and sample gating around the
// coefficient bank, so the FIR never sees a half-updated coefficient set.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int CW    = DEF_CW,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW-1:0]       wr_data,
  input  logic                commit,
  input  logic                sample_en,
  input  logic [7:0]          x_in,
  output logic [7:0]          x_out,
  output logic [NTAPS*CW-1:0] coef,
  output logic                fir_clr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNTW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(NTAPS - 1);

  state_t          state, nstate;
  logic [CNTW-1:0] cnt;
  logic            we, oob, go;

  assign wr_ready = rst && (state == IDLE);
  assign busy     = (state != IDLE);
  assign we       = wr_valid && wr_ready;
  assign oob      = int'(wr_addr) >= NTAPS;
  assign go       = (state == WAIT_SMP) && sample_en;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:     if (commit) nstate = WAIT_SMP;
      WAIT_SMP: if (sample_en) nstate = FLUSH;
      FLUSH:    if (cnt == '0) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x_out   <= '0;
      fir_clr <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nstate;
      fir_clr <= go;
      done    <= (state == FLUSH) && (cnt == '0);
      err     <= we && oob;
      // Samples landing in the flush window are replaced by zeros.
      x_out   <= (nstate == FLUSH) ? '0 : x_in;
      if (go)
        cnt <= CNT_INIT;
      else if (state == FLUSH && cnt != '0)
        cnt <= cnt - CNTW'(1);
    end
  end

  fir_coef_bank #(
    .NTAPS(NTAPS),
    .CW   (CW),
    .AW   (AW)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .addr(wr_addr),
    .data(wr_data),
    .swap(go),
    .coef(coef)
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed table, corner sequences and random stimulus
// checked against a commit-timeline reference model.
module tb_fir_coef_ctrl;
  localparam int NT = 4;
  localparam int CW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_valid = 1'b0;
  logic commit = 1'b0;
  logic sample_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [7:0] x_in = '0;
  logic wr_ready, fir_clr, busy, done, err;
  logic [7:0] x_out;
  logic [NT*CW-1:0] coef;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_coef_ctrl #(.NTAPS(NT), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sample_en(sample_en),
    .x_in(x_in), .x_out(x_out), .coef(coef),
    .fir_clr(fir_clr), .busy(busy), .done(done), .err(err)
  );

  // Reference model: banks as arrays, commit tracked as a timeline
  // (commit cycle m_c, swap cycle m_s) instead of a state machine.
  logic [7:0] m_sh [NT];
  logic [7:0] m_act [NT];
  int m_t, m_c, m_s;
  bit m_done, m_err;
  logic [7:0] m_xp;

  logic s_rdy, s_busy, s_done, s_err, s_clr;
  logic [7:0] s_x;
  logic [31:0] s_coef;

  typedef struct {
    logic wv;
    logic [AW-1:0] wa;
    logic [7:0] wd;
    logic cm, se;
    logic [7:0] xi;
    logic busy, clr, done;
    logic [7:0] x;
    logic [31:0] coef;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, m_t);
    end
  endtask

  function automatic logic [31:0] m_coef();
    logic [31:0] v;
    for (int k = 0; k < NT; k++) v[k*8 +: 8] = m_act[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_sh[k] = 8'h00;
      m_act[k] = 8'h01;
    end
    m_c = -1;
    m_s = -1;
    m_done = 0;
    m_err = 0;
    m_xp = 8'h00;
  endtask

  task automatic step(logic r, logic wv, logic [AW-1:0] wa,
                      logic [7:0] wd, logic cm, logic se,
                      logic [7:0] xi);
    bit fl, rdy;
    rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    commit = cm; sample_en = se; x_in = xi;
    @(negedge clk);
    s_rdy = wr_ready; s_busy = busy; s_done = done; s_err = err;
    s_clr = fir_clr; s_x = x_out; s_coef = coef;
    fl = (m_s >= 0) && (m_t > m_s) && (m_t <= m_s + NT);
    rdy = r && (m_c < 0);
    chk("wr_ready", 32'(s_rdy), 32'(rdy));
    chk("busy", 32'(s_busy), 32'(m_c >= 0));
    chk("done", 32'(s_done), 32'(m_done));
    chk("err", 32'(s_err), 32'(m_err));
    chk("fir_clr", 32'(s_clr), 32'((m_s >= 0) && (m_t == m_s + 1)));
    chk("x_out", 32'(s_x), fl ? 32'd0 : 32'(m_xp));
    chk("coef", s_coef, m_coef());
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_done = (m_s >= 0) && (m_t == m_s + NT);
      m_err = wv && rdy && (int'(wa) >= NT);
      if (wv && rdy && int'(wa) < NT) m_sh[int'(wa)] = wd;
      if (m_c < 0) begin
        if (cm) m_c = m_t;
      end else if (m_s < 0) begin
        if (se && m_t > m_c) begin
          m_s = m_t;
          for (int k = 0; k < NT; k++) m_act[k] = m_sh[k];
        end
      end else if (m_t == m_s + NT) begin
        m_c = -1;
        m_s = -1;
      end
      m_xp = xi;
    end
    m_t++;
    #1;
  endtask

  task automatic nop(logic se);
    step(1'b1, 1'b0, '0, 8'h00, 1'b0, se, 8'($urandom));
  endtask

  task automatic setv(int i, logic wv, logic [AW-1:0] wa, logic [7:0] wd,
                      logic cm, logic se, logic b, logic c, logic d,
                      logic [7:0] x, logic [31:0] cf);
    tbl[i].wv = wv; tbl[i].wa = wa; tbl[i].wd = wd;
    tbl[i].cm = cm; tbl[i].se = se; tbl[i].xi = 8'(8'hA0 + i);
    tbl[i].busy = b; tbl[i].clr = c; tbl[i].done = d;
    tbl[i].x = x; tbl[i].coef = cf;
  endtask

  initial begin
    setv(0,  1, 0, 8'h10, 0, 0, 0, 0, 0, 8'h00, 32'h01010101);
    setv(1,  1, 1, 8'h20, 0, 0, 0, 0, 0, 8'hA0, 32'h01010101);
    setv(2,  1, 2, 8'h30, 0, 0, 0, 0, 0, 8'hA1, 32'h01010101);
    setv(3,  1, 3, 8'h40, 0, 0, 0, 0, 0, 8'hA2, 32'h01010101);
    setv(4,  0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hA3, 32'h01010101);
    setv(5,  0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA4, 32'h01010101);
    setv(6,  0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA5, 32'h01010101);
    setv(7,  0, 0, 8'h00, 0, 1, 1, 0, 0, 8'hA6, 32'h01010101);
    setv(8,  0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 32'h40302010);
    setv(9,  0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 32'h40302010);
    setv(10, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 32'h40302010);
    setv(11, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 32'h40302010);
    setv(12, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'hAB, 32'h40302010);
    setv(13, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hAC, 32'h40302010);

    m_t = 0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'($urandom), AW'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom));
    chk("t1_coef", s_coef, 32'h01010101);
    chk("t1_rdy", 32'(s_rdy), 32'd0);

    // Directed table: writes, commit, delayed strobe, flush, done
    for (int i = 0; i < 14; i++) begin
      step(1'b1, tbl[i].wv, tbl[i].wa, tbl[i].wd,
           tbl[i].cm, tbl[i].se, tbl[i].xi);
      if (i == 0) chk("t1_first_rdy", 32'(s_rdy), 32'd1);
      chk("tbl_busy", 32'(s_busy), 32'(tbl[i].busy));
      chk("tbl_clr", 32'(s_clr), 32'(tbl[i].clr));
      chk("tbl_done", 32'(s_done), 32'(tbl[i].done));
      chk("tbl_x", 32'(s_x), 32'(tbl[i].x));
      chk("tbl_coef", s_coef, tbl[i].coef);
    end

    // Write and commit in the same cycle
    step(1'b1, 1'b1, 3'd2, 8'h55, 1'b1, 1'b0, 8'h11);
    nop(0); nop(0); nop(1);
    for (int i = 0; i < NT + 1; i++) nop(0);
    chk("t3_coef", s_coef, 32'h40552010);

    // Strobe in commit cycle ignored; writes stalled while busy
    step(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b1, 8'h21);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 3'd1, 8'hEE, 1'b0, 1'b0, 8'(8'h30 + i));
      chk("t4_rdy", 32'(s_rdy), 32'd0);
      chk("t4_noswap", s_coef, 32'h40552010);
    end
    step(1'b1, 1'b1, 3'd1, 8'hEE, 1'b0, 1'b1, 8'h40);
    for (int i = 0; i < NT; i++)
      step(1'b1, 1'b1, 3'd1, 8'hEE, 1'b0, 1'b0, 8'h41);
    nop(0);
    chk("t4_done", 32'(s_done), 32'd1);
    chk("t4_coef", s_coef, 32'h40552010);

    // Out-of-range write
    step(1'b1, 1'b1, 3'd5, 8'hFF, 1'b0, 1'b0, 8'h50);
    nop(0);
    chk("t5_err", 32'(s_err), 32'd1);
    nop(0);
    chk("t5_err_clr", 32'(s_err), 32'd0);
    step(1'b1, 1'b0, '0, 8'h00, 1'b1, 1'b0, 8'h51);
    nop(1);
    for (int i = 0; i < NT + 1; i++) nop(0);
    for (int k = 0; k < NT; k++)
      chk("t5_noff", 32'(s_coef[k*8 +: 8] == 8'hFF), 32'd0);
    chk("t5_coef", s_coef, 32'h40552010);

    // Reset during the second flush cycle
    step(1'b1, 1'b1, 3'd0, 8'h77, 1'b1, 1'b0, 8'h60);
    nop(1);
    nop(0);
    step(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 8'h61);
    nop(0);
    chk("t6_coef", s_coef, 32'h01010101);
    chk("t6_rdy", 32'(s_rdy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      nop(0);
      chk("t6_nodone", 32'(s_done), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(63) != 0), 1'($urandom),
           AW'($urandom), 8'($urandom),
           1'($urandom_range(7) == 0), 1'($urandom_range(3) == 0),
           8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
